// File: rtl/spi_mem_responder.sv
// SPI-mode-0 memory responder: decodes READ (0x03) / WRITE (0x02) with a 16-bit address
// and moves bytes through a synchronous memory port, with unbounded bursts while cs is low.
module spi_mem_responder #(
    parameter int SYNC_STAGES = 2,
    parameter bit READ_ONLY   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        cmd_err
);
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE} state_t;
    state_t state;

    logic [STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_prev, cs_prev;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall;

    // cs synchronizer resets to the deselected level so a held-low cs still reads as a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[STAGES-1];
            cs_prev   <= cs_sync[STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[STAGES-1];
    assign cs_s      = cs_sync[STAGES-1];
    assign mosi_s    = mosi_sync[STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    logic [3:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [14:0] addr_sh;
    logic [7:0]  tx_sh;
    logic [7:0]  byte_in;
    logic        is_read;
    logic        load_tx;

    assign byte_in = {shift_in, mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd7;
            shift_in  <= '0;
            addr_sh   <= '0;
            tx_sh     <= '0;
            is_read   <= 1'b0;
            load_tx   <= 1'b0;
            miso      <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            cmd_err <= 1'b0;
            // read data arrives the clk after mem_re; capture it one clk later still
            load_tx <= mem_re;
            if (load_tx) tx_sh <= mem_rdata;
            if (mem_we) mem_addr <= mem_addr + 16'd1;

            if (cs_s) begin
                state   <= S_IDLE;
                bit_cnt <= 4'd7;
                miso    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state   <= S_CMD;
                            busy    <= 1'b1;
                            bit_cnt <= 4'd7;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            shift_in <= byte_in[6:0];
                            if (bit_cnt == 4'd0) begin
                                bit_cnt <= 4'd15;
                                if (byte_in == CMD_READ) begin
                                    is_read <= 1'b1;
                                    state   <= S_ADDR;
                                end else if (byte_in == CMD_WRITE && !READ_ONLY) begin
                                    is_read <= 1'b0;
                                    state   <= S_ADDR;
                                end else begin
                                    cmd_err <= 1'b1;
                                    state   <= S_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            addr_sh <= {addr_sh[13:0], mosi_s};
                            if (bit_cnt == 4'd0) begin
                                mem_addr <= {addr_sh, mosi_s};
                                bit_cnt  <= 4'd7;
                                if (is_read) begin
                                    mem_re <= 1'b1;
                                    state  <= S_READ;
                                end else begin
                                    state  <= S_WRITE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                            end
                        end
                    end
                    S_READ: begin
                        if (sclk_fall) begin
                            miso  <= tx_sh[7];
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            if (bit_cnt == 4'd0) begin
                                mem_addr <= mem_addr + 16'd1;
                                mem_re   <= 1'b1;
                                bit_cnt  <= 4'd7;
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (sclk_rise) begin
                            shift_in <= byte_in[6:0];
                            if (bit_cnt == 4'd0) begin
                                mem_wdata <= byte_in;
                                mem_we    <= 1'b1;
                                bit_cnt   <= 4'd7;
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                            end
                        end
                    end
                    default: begin
                        miso <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: bit-banged SPI master, memory model, and a scoreboard that
// checks memory-port events and master-sampled miso bytes against expected queues.
module tb_spi_mem_responder;
    localparam int HALF = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sclk, cs, mosi;
    logic miso, mem_re, mem_we, busy, cmd_err;
    logic [15:0] mem_addr;
    logic [7:0] mem_rdata, mem_wdata;
    logic miso2, mem_re2, mem_we2, busy2, cmd_err2;
    logic [15:0] mem_addr2;
    logic [7:0] mem_wdata2, rom_rdata;

    spi_mem_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .busy(busy), .cmd_err(cmd_err)
    );

    spi_mem_responder #(.READ_ONLY(1'b1)) rom (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso2),
        .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_rdata(rom_rdata), .mem_we(mem_we2),
        .mem_wdata(mem_wdata2), .busy(busy2), .cmd_err(cmd_err2)
    );

    logic [7:0] mem [0:65535];
    logic pre_we;
    logic [15:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    int err2_cnt = 0;
    int we2_cnt = 0;
    logic [27:0] exp_q[$];
    logic [7:0] rx_exp_q[$];
    logic rx_strobe = 1'b0;
    logic [7:0] rx_byte;

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_evt(input string name, input logic [27:0] act);
        logic [27:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected event %h, expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // monitor: every memory-port strobe and every completed master byte is scored
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re && mem_we) begin
                n_vec++;
                n_err++;
                $display("FAIL re_we_overlap: got both strobes at addr %h, expected at most one", mem_addr);
            end
            if (mem_re) check_evt("mem_re", {4'h1, mem_addr, 8'h00});
            if (mem_we) check_evt("mem_we", {4'h2, mem_addr, mem_wdata});
            if (cmd_err) check_evt("cmd_err", {4'h3, 16'h0000, 8'h00});
            if (rx_strobe) begin
                if (rx_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL miso_byte: got %h, expected no byte", rx_byte);
                end else begin
                    check("miso_byte", {20'd0, rx_byte}, {20'd0, rx_exp_q.pop_front()});
                end
            end
        end
        if (cmd_err2) err2_cnt++;
        if (mem_we2) we2_cnt++;
    end

    task automatic push_re(input logic [15:0] a);
        exp_q.push_back({4'h1, a, 8'h00});
    endtask

    task automatic push_we(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({4'h2, a, d});
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_begin();
        cs = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic spi_end();
        wait_clks(HALF);
        cs = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clks(HALF);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp_rx);
        logic [7:0] rx;
        rx_exp_q.push_back(exp_rx);
        spi_bits(tx, 8, rx);
        rx_byte = rx;
        rx_strobe = 1'b1;
        wait_clks(1);
        rx_strobe = 1'b0;
    endtask

    task automatic read_one(input logic [15:0] a, input logic [7:0] d);
        push_re(a);
        push_re(a + 16'd1);
        spi_begin();
        spi_byte(8'h03, 8'h00);
        spi_byte(a[15:8], 8'h00);
        spi_byte(a[7:0], 8'h00);
        spi_byte(8'h00, d);
        spi_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, {27'd0, miso}, 28'd0);
        check({tag, "_mem_re"}, {27'd0, mem_re}, 28'd0);
        check({tag, "_mem_we"}, {27'd0, mem_we}, 28'd0);
        check({tag, "_mem_addr"}, {12'd0, mem_addr}, 28'd0);
        check({tag, "_mem_wdata"}, {20'd0, mem_wdata}, 28'd0);
        check({tag, "_busy"}, {27'd0, busy}, 28'd0);
        check({tag, "_cmd_err"}, {27'd0, cmd_err}, 28'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end of run within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] junk;
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; rom_rdata = 8'h00;
        pre_we = 1'b0; pre_addr = 16'h0000; pre_data = 8'h00;
        wait_clks(1);
        pre_we = 1'b1; pre_addr = 16'h1234; pre_data = 8'hA7;
        wait_clks(1);
        pre_we = 1'b0;
        wait_clks(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clks(4);

        // plain read of a preloaded byte
        push_re(16'h1234);
        push_re(16'h1235);
        spi_begin();
        spi_byte(8'h03, 8'h00);
        spi_byte(8'h12, 8'h00);
        spi_byte(8'h34, 8'h00);
        check("busy_mid_read", {27'd0, busy}, 28'd1);
        spi_byte(8'h00, 8'hA7);
        spi_end();
        check("busy_after_read", {27'd0, busy}, 28'd0);

        // single write then read back
        push_we(16'h00FF, 8'h5A);
        spi_begin();
        spi_byte(8'h02, 8'h00);
        spi_byte(8'h00, 8'h00);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'h5A, 8'h00);
        spi_end();
        read_one(16'h00FF, 8'h5A);

        // burst write across the 0xFFFF wrap, then burst read
        push_we(16'hFFFE, 8'h11);
        push_we(16'hFFFF, 8'h22);
        push_we(16'h0000, 8'h33);
        spi_begin();
        spi_byte(8'h02, 8'h00);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'hFE, 8'h00);
        spi_byte(8'h11, 8'h00);
        spi_byte(8'h22, 8'h00);
        spi_byte(8'h33, 8'h00);
        spi_end();
        push_re(16'hFFFF);
        push_re(16'h0000);
        push_re(16'h0001);
        spi_begin();
        spi_byte(8'h03, 8'h00);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'h00, 8'h22);
        spi_byte(8'h00, 8'h33);
        spi_end();

        // unknown command then 24 clocks
        exp_q.push_back({4'h3, 16'h0000, 8'h00});
        spi_begin();
        spi_byte(8'h9F, 8'h00);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'hFF, 8'h00);
        spi_byte(8'hFF, 8'h00);
        spi_end();

        // write aborted after 4 data bits, then a clean read
        spi_begin();
        spi_byte(8'h02, 8'h00);
        spi_byte(8'h00, 8'h00);
        spi_byte(8'h40, 8'h00);
        spi_bits(8'hC3, 4, junk);
        spi_end();
        read_one(16'h1234, 8'hA7);

        // reset during the address phase of a read
        spi_begin();
        spi_byte(8'h03, 8'h00);
        spi_byte(8'h12, 8'h00);
        wait_clks(2);
        rst = 1'b1;
        wait_clks(1);
        check_reset_outputs("midreset");
        rst = 1'b0;
        spi_end();
        check("busy_after_midreset", {27'd0, busy}, 28'd0);
        read_one(16'h00FF, 8'h5A);

        wait_clks(10);
        check("exp_q_drained", 28'(exp_q.size()), 28'd0);
        check("rx_q_drained", 28'(rx_exp_q.size()), 28'd0);
        check("rom_cmd_err_count", 28'(err2_cnt), 28'd4);
        check("rom_mem_we_count", 28'(we2_cnt), 28'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
